// File: rtl/fifo_sync_ctrl_if.sv
// Handshake bundle for fifo_sync_ctrl.
// Carries flush, data, strobes, thresholds, head word, occupancy and status flags.
interface fifo_sync_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic             i_clr;
    logic [WIDTH-1:0] i_dat;
    logic             i_push;
    logic             i_pop;
    logic [DEPTH:0]   i_af_thresh;
    logic [DEPTH:0]   i_ae_thresh;
    logic             i_err_clr;
    logic [WIDTH-1:0] o_dat;
    logic [DEPTH:0]   o_count;
    logic             o_empty;
    logic             o_full;
    logic             o_half;
    logic             o_almost_empty;
    logic             o_almost_full;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_clr, i_dat, i_push, i_pop,
        output i_af_thresh, i_ae_thresh, i_err_clr,
        input  o_dat, o_count, o_empty, o_full, o_half,
        input  o_almost_empty, o_almost_full,
        input  o_overflow, o_underflow
    );

    modport slave (
        input  i_clr, i_dat, i_push, i_pop,
        input  i_af_thresh, i_ae_thresh, i_err_clr,
        output o_dat, o_count, o_empty, o_full, o_half,
        output o_almost_empty, o_almost_full,
        output o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Synchronous first-word-fall-through FIFO with edge/level strobes.
// Ports: i_clk, i_reset_n (async, active-low), bus (fifo_sync_ctrl_if.slave).
module fifo_sync_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int EDGE  = 1
) (
    input logic           i_clk,
    input logic           i_reset_n,
    fifo_sync_ctrl_if.slave bus
);
    localparam int             N        = 1 << DEPTH;
    localparam logic [DEPTH:0] FULL_CNT = N[DEPTH:0];
    localparam logic [DEPTH:0] HALF_CNT = FULL_CNT >> 1;

    logic [WIDTH-1:0] mem [N];
    logic [DEPTH-1:0] rd_idx;
    logic [DEPTH-1:0] wr_idx;
    logic [DEPTH:0]   count;
    logic             push_d;
    logic             pop_d;
    logic             ovf;
    logic             ufl;
    logic             push_req;
    logic             pop_req;
    logic             push_ok;
    logic             pop_ok;
    logic             empty;
    logic             full;

    // Edge mode masks a strobe that was already high last cycle.
    assign push_req = bus.i_push & ~((EDGE != 0) ? push_d : 1'b0);
    assign pop_req  = bus.i_pop  & ~((EDGE != 0) ? pop_d  : 1'b0);

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    // A full FIFO still takes a push when the head leaves the same cycle.
    assign pop_ok  = pop_req & ~empty;
    assign push_ok = push_req & (~full | pop_ok);

    assign bus.o_dat          = mem[rd_idx];
    assign bus.o_count        = count;
    assign bus.o_empty        = empty;
    assign bus.o_full         = full;
    assign bus.o_half         = (count < HALF_CNT);
    assign bus.o_almost_empty = (count <= bus.i_ae_thresh);
    assign bus.o_almost_full  = (count >= bus.i_af_thresh);
    assign bus.o_overflow     = ovf;
    assign bus.o_underflow    = ufl;

    always_ff @(posedge i_clk) begin
        if (!bus.i_clr && push_ok)
            mem[wr_idx] <= bus.i_dat;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
            push_d <= 1'b0;
            pop_d  <= 1'b0;
            ovf    <= 1'b0;
            ufl    <= 1'b0;
        end else begin
            push_d <= bus.i_push;
            pop_d  <= bus.i_pop;
            if (bus.i_clr) begin
                rd_idx <= '0;
                wr_idx <= '0;
                count  <= '0;
                ovf    <= ovf & ~bus.i_err_clr;
                ufl    <= ufl & ~bus.i_err_clr;
            end else begin
                if (push_ok)
                    wr_idx <= wr_idx + DEPTH'(1);
                if (pop_ok)
                    rd_idx <= rd_idx + DEPTH'(1);
                unique case ({push_ok, pop_ok})
                    2'b10:   count <= count + (DEPTH+1)'(1);
                    2'b01:   count <= count - (DEPTH+1)'(1);
                    default: count <= count;
                endcase
                // A new error outranks a coincident clear.
                ovf <= (ovf & ~bus.i_err_clr) | (push_req & ~push_ok);
                ufl <= (ufl & ~bus.i_err_clr) | (pop_req & ~pop_ok);
            end
        end
    end
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Scoreboard bench for fifo_sync_ctrl (edge and level instances, DEPTH=2).
// Popped words are checked by a monitor against a queue filled by stimulus.
module tb_fifo_sync_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_tot = 0;
    logic [7:0] sbq [$];

    always #5 clk = ~clk;

    fifo_sync_ctrl_if #(.WIDTH(8), .DEPTH(2)) be ();
    fifo_sync_ctrl_if #(.WIDTH(8), .DEPTH(2)) bl ();

    fifo_sync_ctrl #(.WIDTH(8), .DEPTH(2), .EDGE(1)) u_edge (
        .i_clk(clk), .i_reset_n(rst_n), .bus(be)
    );
    fifo_sync_ctrl #(.WIDTH(8), .DEPTH(2), .EDGE(0)) u_lvl (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bl)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: every accepted pop on the level instance must show the
    // oldest word still owed by the scoreboard.
    always @(negedge clk) begin
        if (rst_n && !bl.i_clr && bl.i_pop && !bl.o_empty) begin
            if (sbq.size() == 0) begin
                n_tot++;
                $display("FAIL pop_data: got %0h expected nothing", bl.o_dat);
            end else begin
                chk("pop_data", {24'd0, bl.o_dat}, {24'd0, sbq.pop_front()});
            end
        end
    end

    task automatic cyc(input logic p, input logic q, input logic [7:0] d,
                       input logic expect_acc);
        bl.i_push = p;
        bl.i_pop  = q;
        bl.i_dat  = d;
        if (expect_acc) sbq.push_back(d);
        @(posedge clk);
        #1;
        bl.i_push = 1'b0;
        bl.i_pop  = 1'b0;
    endtask

    logic [1:0] wp [17] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 2'b01,
                            2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b10,
                            2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
    int         wc [17] = '{1, 2, 2, 3, 2, 1, 1, 2, 3, 3, 2, 3,
                            2, 3, 2, 1, 0};
    logic       tae [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       taf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [7:0] v;
        be.i_clr = 0; be.i_dat = 0; be.i_push = 0; be.i_pop = 0;
        be.i_af_thresh = 3'd3; be.i_ae_thresh = 3'd1; be.i_err_clr = 0;
        bl.i_clr = 0; bl.i_dat = 0; bl.i_push = 0; bl.i_pop = 0;
        bl.i_af_thresh = 3'd3; bl.i_ae_thresh = 3'd1; bl.i_err_clr = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_count", bl.o_count, 0);
        chk("rst_empty", bl.o_empty, 1);
        chk("rst_full", bl.o_full, 0);
        chk("rst_half", bl.o_half, 1);
        chk("rst_ae", bl.o_almost_empty, 1);
        chk("rst_af", bl.o_almost_full, 0);
        chk("rst_ovf", bl.o_overflow, 0);
        chk("rst_ufl", bl.o_underflow, 0);

        // Edge mode: a strobe held three cycles writes once.
        be.i_dat = 8'hA5;
        be.i_push = 1'b1;
        repeat (3) @(posedge clk);
        #1 be.i_push = 1'b0;
        chk("edge_count", be.o_count, 1);
        chk("edge_dat", be.o_dat, 8'hA5);
        chk("edge_empty", be.o_empty, 0);

        // Level mode fill and overflow.
        for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(i), 1);
        cyc(1, 0, 8'h05, 0);
        chk("ovf_full", bl.o_full, 1);
        chk("ovf_count", bl.o_count, 4);
        chk("ovf_flag", bl.o_overflow, 1);
        chk("ovf_head", bl.o_dat, 8'h01);
        bl.i_err_clr = 1'b1;
        cyc(0, 0, 8'h00, 0);
        bl.i_err_clr = 1'b0;
        chk("ovf_clr", bl.o_overflow, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00, 0);
        chk("drain_empty", bl.o_empty, 1);

        // Full FIFO with simultaneous push and pop.
        for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(i), 1);
        cyc(1, 1, 8'h09, 1);
        chk("pp_count", bl.o_count, 4);
        chk("pp_ovf", bl.o_overflow, 0);
        chk("pp_head", bl.o_dat, 8'h02);
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00, 0);
        chk("pp_empty", bl.o_empty, 1);

        // Empty FIFO with simultaneous push and pop.
        cyc(1, 1, 8'h07, 1);
        chk("ep_count", bl.o_count, 1);
        chk("ep_dat", bl.o_dat, 8'h07);
        chk("ep_ufl", bl.o_underflow, 1);
        cyc(0, 1, 8'h00, 0);
        bl.i_err_clr = 1'b1;
        cyc(0, 0, 8'h00, 0);
        bl.i_err_clr = 1'b0;
        chk("ufl_clr", bl.o_underflow, 0);

        // Wrap-around with mixed occupancy.
        v = 8'h20;
        for (int i = 0; i < 17; i++) begin
            cyc(wp[i][1], wp[i][0], v, wp[i][1]);
            if (wp[i][1]) v = v + 8'd1;
            chk("wrap_count", bl.o_count, wc[i]);
            chk("wrap_half", bl.o_half, (wc[i] < 2) ? 1 : 0);
        end

        // Thresholds af=3, ae=1.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc(1, 0, 8'(8'h30 + i), 1);
            chk("thr_ae", bl.o_almost_empty, tae[i]);
            chk("thr_af", bl.o_almost_full, taf[i]);
        end
        bl.i_af_thresh = 3'd5;
        #1;
        chk("thr_af5", bl.o_almost_full, 0);
        bl.i_af_thresh = 3'd3;

        // Flush with a coincident push.
        cyc(0, 1, 8'h00, 0);
        chk("fl_pre", bl.o_count, 3);
        bl.i_clr = 1'b1;
        cyc(1, 0, 8'hEE, 0);
        bl.i_clr = 1'b0;
        sbq.delete();
        chk("fl_count", bl.o_count, 0);
        chk("fl_empty", bl.o_empty, 1);
        chk("fl_ovf", bl.o_overflow, 0);

        // Async reset mid-stream.
        cyc(0, 1, 8'h00, 0);
        chk("ar_ufl_set", bl.o_underflow, 1);
        cyc(1, 0, 8'h41, 1);
        cyc(1, 0, 8'h42, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count", bl.o_count, 0);
        chk("ar_empty", bl.o_empty, 1);
        chk("ar_half", bl.o_half, 1);
        chk("ar_ae", bl.o_almost_empty, 1);
        chk("ar_ufl", bl.o_underflow, 0);
        sbq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
